// File: rtl/nco_pkg.sv
// rtl/nco_pkg.sv - shared types and elaboration-time helpers for the multichannel NCO
package nco_pkg;

  typedef enum logic [1:0] {
    SINE     = 2'd0,
    SQUARE   = 2'd1,
    TRIANGLE = 2'd2,
    SAW      = 2'd3
  } wave_t;

  function automatic int midscale(input int out_w);
    return 1 << (out_w - 1);
  endfunction

  // Integer Taylor series in Q30 so the table folds to constants without real math.
  function automatic int sine_mag(input int idx, input int addr_w, input int out_w);
    longint x;
    longint term;
    longint sum;
    longint amp;
    x    = (longint'(64'sd3373259426) * longint'(idx)) >>> (addr_w + 1);
    term = x;
    sum  = x;
    for (int k = 1; k <= 6; k++) begin
      term = (term * x) >>> 30;
      term = (term * x) >>> 30;
      term = -term / longint'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    amp = longint'((1 << (out_w - 1)) - 1);
    return int'((sum * amp + (longint'(1) <<< 29)) >>> 30);
  endfunction

endpackage

// File: rtl/nco_wave_shaper.sv
// rtl/nco_wave_shaper.sv - combinational phase-to-sample shaper with quarter-wave sine table
module nco_wave_shaper
  import nco_pkg::*;
#(
  parameter int PHASE_W = 10,
  parameter int OUT_W   = 8
) (
  input  logic [PHASE_W-1:0] p,
  input  wave_t              wave,
  output logic [OUT_W-1:0]   sample
);

  localparam int LUT_AW = PHASE_W - 2;
  localparam logic [OUT_W-1:0] MID = OUT_W'(midscale(OUT_W));

  logic [OUT_W-1:0]  lut [2**LUT_AW];
  logic [LUT_AW-1:0] addr;
  logic [OUT_W-1:0]  mag;
  logic [OUT_W-1:0]  tri_q;

  for (genvar i = 0; i < 2**LUT_AW; i++) begin : g_lut
    localparam int MAG = sine_mag(i, LUT_AW, OUT_W);
    assign lut[i] = OUT_W'(MAG);
  end

  always_comb begin
    // second and fourth quadrants walk the table backwards
    addr   = p[PHASE_W-2] ? ~p[LUT_AW-1:0] : p[LUT_AW-1:0];
    mag    = lut[addr];
    tri_q  = p[PHASE_W-2 -: OUT_W];
    sample = MID;
    case (wave)
      SAW:      sample = p[PHASE_W-1 -: OUT_W];
      SQUARE:   sample = p[PHASE_W-1] ? '0 : '1;
      TRIANGLE: sample = p[PHASE_W-1] ? ~tri_q : tri_q;
      default:  sample = p[PHASE_W-1] ? MID - mag : MID + mag;
    endcase
  end

endmodule

// File: rtl/nco_multichannel.sv
// rtl/nco_multichannel.sv - NUM_CH phase accumulators with shadowed config and 2-cycle sample pipe
module nco_multichannel
  import nco_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int ACC_W   = 32,
  parameter int PHASE_W = 10,
  parameter int OUT_W   = 8,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk_50MHz,
  input  logic                    rst,
  input  logic                    sample_en,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [ACC_W-1:0]        cfg_ftw,
  input  logic [PHASE_W-1:0]      cfg_phase,
  input  logic [1:0]              cfg_wave,
  input  logic                    cfg_sync,
  output logic [NUM_CH*OUT_W-1:0] sample_out,
  output logic                    sample_valid
);

  localparam logic [OUT_W-1:0] MID = OUT_W'(midscale(OUT_W));

  logic [ACC_W-1:0]   acc       [NUM_CH];
  logic [ACC_W-1:0]   ftw       [NUM_CH];
  logic [PHASE_W-1:0] phase_off [NUM_CH];
  wave_t              wave      [NUM_CH];
  logic [ACC_W-1:0]   sh_ftw    [NUM_CH];
  logic [PHASE_W-1:0] sh_phase  [NUM_CH];
  wave_t              sh_wave   [NUM_CH];
  logic [NUM_CH-1:0]  sh_sync;
  logic [NUM_CH-1:0]  pending;

  logic [NUM_CH-1:0]  commit;
  logic [ACC_W-1:0]   eff_ftw   [NUM_CH];
  logic [PHASE_W-1:0] eff_phase [NUM_CH];
  wave_t              eff_wave  [NUM_CH];
  logic [ACC_W-1:0]   a         [NUM_CH];

  logic [PHASE_W-1:0] p_q       [NUM_CH];
  wave_t              wave_q    [NUM_CH];
  logic               p_valid;
  logic [OUT_W-1:0]   shaped    [NUM_CH];

  logic in_range;
  logic pend_sel;
  logic cfg_fire;

  assign in_range = (32'(cfg_ch) < NUM_CH);

  always_comb begin
    pend_sel = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cfg_ch == CH_W'(c)) pend_sel = pending[c];
    end
  end

  // Out-of-range channels always accept so the writer never stalls on them.
  assign cfg_ready = !in_range || !pend_sel;
  assign cfg_fire  = cfg_valid && cfg_ready && in_range;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      commit[c]    = sample_en && pending[c];
      eff_ftw[c]   = commit[c] ? sh_ftw[c]   : ftw[c];
      eff_phase[c] = commit[c] ? sh_phase[c] : phase_off[c];
      eff_wave[c]  = commit[c] ? sh_wave[c]  : wave[c];
      a[c]         = (commit[c] && sh_sync[c]) ? '0 : acc[c];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_shaper
    nco_wave_shaper #(
      .PHASE_W(PHASE_W),
      .OUT_W  (OUT_W)
    ) u_shaper (
      .p     (p_q[g]),
      .wave  (wave_q[g]),
      .sample(shaped[g])
    );
  end

  always_ff @(posedge clk_50MHz) begin
    if (!rst) begin
      p_valid      <= 1'b0;
      sample_valid <= 1'b0;
      pending      <= '0;
      sh_sync      <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        acc[c]       <= '0;
        ftw[c]       <= '0;
        phase_off[c] <= '0;
        wave[c]      <= SINE;
        sh_ftw[c]    <= '0;
        sh_phase[c]  <= '0;
        sh_wave[c]   <= SINE;
        p_q[c]       <= '0;
        wave_q[c]    <= SINE;
        sample_out[c*OUT_W +: OUT_W] <= MID;
      end
    end else begin
      p_valid      <= sample_en;
      sample_valid <= p_valid;
      for (int c = 0; c < NUM_CH; c++) begin
        if (cfg_fire && (cfg_ch == CH_W'(c))) begin
          sh_ftw[c]   <= cfg_ftw;
          sh_phase[c] <= cfg_phase;
          sh_wave[c]  <= wave_t'(cfg_wave);
          sh_sync[c]  <= cfg_sync;
          pending[c]  <= 1'b1;
        end
        if (sample_en) begin
          acc[c]    <= a[c] + eff_ftw[c];
          p_q[c]    <= a[c][ACC_W-1 -: PHASE_W] + eff_phase[c];
          wave_q[c] <= eff_wave[c];
        end
        if (commit[c]) begin
          ftw[c]       <= sh_ftw[c];
          phase_off[c] <= sh_phase[c];
          wave[c]      <= sh_wave[c];
          pending[c]   <= 1'b0;
        end
        if (p_valid) sample_out[c*OUT_W +: OUT_W] <= shaped[c];
      end
    end
  end

endmodule
